// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serialises configuration words LSB-first onto a tile configuration chain (optional readback: CCFF_LOADER_READBACK_EN).
// Latency: start -> word_ready next cycle; word accept -> shift_en for the next min(WORD_W, remaining) cycles; done 1 cycle after last shift.
// Backpressure: word_ready is high only in LOAD; word_valid low there stalls the load with shift_en=0 and the chain holding.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 24,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail_in,
`ifdef CCFF_LOADER_READBACK_EN
    output logic              rb_bit,
    output logic              rb_valid,
`endif
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int               IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;      // bits of the current word not yet presented on ccff_head
    logic [CNT_W-1:0]  remaining;  // chain bits still to be shifted, including the one on ccff_head now
    logic [IDX_W-1:0]  bit_idx;    // position within the current word of the bit on ccff_head

    // Load sequencer: all outputs are registered so ccff_head and shift_en change together.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state      <= IDLE;
            shreg      <= '0;
            remaining  <= '0;
            bit_idx    <= '0;
            word_ready <= 1'b0;
            ccff_head  <= 1'b0;
            shift_en   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    // abort in the same cycle as start cancels the request
                    if (start && !abort) begin
                        state      <= LOAD;
                        word_ready <= 1'b1;
                        busy       <= 1'b1;
                        remaining  <= FULL_CNT;
                        bit_idx    <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state      <= IDLE;
                        word_ready <= 1'b0;
                        busy       <= 1'b0;
                        aborted    <= 1'b1;
                    end else if (word_valid) begin
                        state      <= SHIFT;
                        word_ready <= 1'b0;
                        shift_en   <= 1'b1;
                        ccff_head  <= word_data[0];
                        shreg      <= word_data >> 1;
                        bit_idx    <= '0;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state     <= IDLE;
                        shift_en  <= 1'b0;
                        ccff_head <= 1'b0;
                        busy      <= 1'b0;
                        aborted   <= 1'b1;
                    end else begin
                        remaining <= remaining - ONE_CNT;
                        if (remaining == ONE_CNT) begin
                            // last chain bit: upper bits of a partial word are dropped here
                            state     <= DONE;
                            shift_en  <= 1'b0;
                            ccff_head <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (bit_idx == LAST_IDX) begin
                            state      <= LOAD;
                            shift_en   <= 1'b0;
                            ccff_head  <= 1'b0;
                            word_ready <= 1'b1;
                        end else begin
                            ccff_head <= shreg[0];
                            shreg     <= shreg >> 1;
                            bit_idx   <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CCFF_LOADER_READBACK_EN
    // Capture the bit leaving the chain tail on every shifting edge.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            rb_bit   <= 1'b0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= shift_en;
            if (shift_en) begin
                rb_bit <= ccff_tail_in;
            end
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail_in;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: drives a 24-bit and a 20-bit chain loader with shared stimulus, scoreboard on head/readback bits.
// Latency: checks start->ready, accept->shift and last-shift->done timing against the protocol rules.
// Backpressure: inserts word_valid gaps during LOAD and checks the chain holds.
`timescale 1ns/1ps
module tb_ccff_bitstream_loader;

    localparam int WW  = 8;
    localparam int CL0 = 24;
    localparam int CL1 = 20;

    logic           prog_clk = 1'b0;
    logic           prog_reset_n;
    logic           start;
    logic           abort;
    logic           word_valid;
    logic [WW-1:0]  word_data;
    logic [1:0]     word_ready, ccff_head, shift_en, busy, done, aborted;
`ifdef CCFF_LOADER_READBACK_EN
    logic [1:0]     rb_bit, rb_valid;
`endif
    // external chain models, preloaded with a known old image
    logic [CL0-1:0] chain0 = 24'hC35A96;
    logic [CL1-1:0] chain1 = 20'h93E71;

    int total = 0;
    int bad   = 0;
    int n_shift[2], n_done[2], n_abort[2], n_rdy[2], n_rb[2];
    bit prev_se[2], acc_pend[2];
    bit exp_q0[$], exp_q1[$], rb_q0[$], rb_q1[$];
    logic [WW-1:0] words[3];
    int gaps[3];

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(.CHAIN_LEN(CL0), .WORD_W(WW)) dut0 (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start), .abort(abort),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready[0]),
        .ccff_head(ccff_head[0]), .shift_en(shift_en[0]), .ccff_tail_in(chain0[CL0-1]),
`ifdef CCFF_LOADER_READBACK_EN
        .rb_bit(rb_bit[0]), .rb_valid(rb_valid[0]),
`endif
        .busy(busy[0]), .done(done[0]), .aborted(aborted[0]));

    ccff_bitstream_loader #(.CHAIN_LEN(CL1), .WORD_W(WW)) dut1 (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start), .abort(abort),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready[1]),
        .ccff_head(ccff_head[1]), .shift_en(shift_en[1]), .ccff_tail_in(chain1[CL1-1]),
`ifdef CCFF_LOADER_READBACK_EN
        .rb_bit(rb_bit[1]), .rb_valid(rb_valid[1]),
`endif
        .busy(busy[1]), .done(done[1]), .aborted(aborted[1]));

    // chain flops: head enters position 0, position CL-1 feeds the tail
    always @(posedge prog_clk) begin
        if (shift_en[0] === 1'b1) chain0 <= {chain0[CL0-2:0], ccff_head[0]};
        if (shift_en[1] === 1'b1) chain1 <= {chain1[CL1-2:0], ccff_head[1]};
    end

    function automatic int cl(input int d);
        return (d == 0) ? CL0 : CL1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pop_bit(input int d, input bit rb, output bit b);
        b = 1'b0;
        pop_bit = 1'b0;
        if (!rb && d == 0 && exp_q0.size() > 0) begin b = exp_q0.pop_front(); pop_bit = 1'b1; end
        if (!rb && d == 1 && exp_q1.size() > 0) begin b = exp_q1.pop_front(); pop_bit = 1'b1; end
        if (rb && d == 0 && rb_q0.size() > 0) begin b = rb_q0.pop_front(); pop_bit = 1'b1; end
        if (rb && d == 1 && rb_q1.size() > 0) begin b = rb_q1.pop_front(); pop_bit = 1'b1; end
    endfunction

    // image the chain must hold after a full load: stream bit k sits at position CL-1-k
    function automatic logic [31:0] exp_img(input int d);
        logic [31:0] v = '0;
        for (int k = 0; k < cl(d); k++) v[cl(d)-1-k] = words[k/WW][k%WW];
        return v;
    endfunction

    // Monitor: pops expected bits whenever a DUT shifts or presents a readback bit.
    always @(negedge prog_clk) begin
        bit b;
        for (int d = 0; d < 2; d++) begin
            if (acc_pend[d]) check($sformatf("accept_to_shift[%0d]", d), shift_en[d], 1);
            acc_pend[d] = (prog_reset_n === 1'b1) && (abort === 1'b0) &&
                          (word_valid === 1'b1) && (word_ready[d] === 1'b1);
            if (shift_en[d] === 1'b1) begin
                n_shift[d]++;
                if (pop_bit(d, 1'b0, b)) check($sformatf("head_bit[%0d]", d), ccff_head[d], b);
                else check($sformatf("shifts_exceed_chain[%0d]", d), n_shift[d], cl(d));
            end else begin
                check($sformatf("head_idle_zero[%0d]", d), ccff_head[d], 0);
            end
            if (shift_en[d] === 1'b1 || word_ready[d] === 1'b1)
                check($sformatf("busy_when_active[%0d]", d), busy[d], 1);
            if (done[d] === 1'b1) begin
                n_done[d]++;
                check($sformatf("done_after_last_shift[%0d]", d), prev_se[d] ? n_shift[d] : -1, cl(d));
            end
            if (aborted[d] === 1'b1) n_abort[d]++;
            if (word_ready[d] === 1'b1) n_rdy[d]++;
`ifdef CCFF_LOADER_READBACK_EN
            if (rb_valid[d] === 1'b1) begin
                n_rb[d]++;
                if (pop_bit(d, 1'b1, b)) check($sformatf("rb_bit[%0d]", d), rb_bit[d], b);
                else check($sformatf("rb_exceeds_chain[%0d]", d), n_rb[d], cl(d));
            end
`endif
            prev_se[d] = (shift_en[d] === 1'b1);
        end
    end

    // Scoreboard fill: the expected head stream is the word stream truncated to the chain length,
    // the expected readback is the old image from the tail end.
    task automatic prep_load();
        check("idle_before_start", {busy, shift_en, word_ready, done}, 0);
        exp_q0.delete(); exp_q1.delete(); rb_q0.delete(); rb_q1.delete();
        for (int k = 0; k < CL0; k++) begin exp_q0.push_back(words[k/WW][k%WW]); rb_q0.push_back(chain0[CL0-1-k]); end
        for (int k = 0; k < CL1; k++) begin exp_q1.push_back(words[k/WW][k%WW]); rb_q1.push_back(chain1[CL1-1-k]); end
        for (int d = 0; d < 2; d++) begin
            n_shift[d] = 0; n_done[d] = 0; n_abort[d] = 0; n_rdy[d] = 0; n_rb[d] = 0;
        end
    endtask

    // mode: 0 plain, 1 reset after stop_at shifts, 2 abort after stop_at shifts, 3 start while busy
    task automatic run_load(input int mode, input int stop_at);
        int wi = 0, gap_left = gaps[0], cyc = 0, gap_total = 0, fire_cyc = 0;
        bit fired = 0, finished = 0, acc;
        prep_load();
        start = 1;
        @(posedge prog_clk); #1;
        start = 0;
        while (!finished) begin
            word_valid = (wi < 3) && (gap_left == 0);
            if (wi < 3) word_data = words[wi];
            if (mode != 0 && !fired && n_shift[0] >= stop_at) begin
                fired = 1; fire_cyc = cyc;
                if (mode == 1) prog_reset_n = 0;
                else if (mode == 2) abort = 1;
                else start = 1;
            end
            @(negedge prog_clk);
            if (cyc == 0) check("start_to_ready", {busy, word_ready}, 4'hF);
            if (fired && cyc == fire_cyc + 1) begin
                if (mode == 1) check("reset_clears_outputs", {word_ready, ccff_head, shift_en, busy, done, aborted}, 0);
                if (mode == 2) check("abort_pulse", {aborted, done, busy, shift_en, word_ready}, 10'b11_0000_0000);
            end
            acc = word_valid && (word_ready[0] === 1'b1) && !abort && prog_reset_n;
            if (!word_valid && wi < 3 && word_ready[0] === 1'b1 && gap_left > 0) begin
                gap_left--; gap_total++;
                check("stall_holds_chain", shift_en, 0);
            end
            @(posedge prog_clk); #1;
            prog_reset_n = 1; abort = 0; start = 0;
            if (acc) begin wi++; gap_left = (wi < 3) ? gaps[wi] : 0; end
            cyc++;
            if (mode == 1 || mode == 2) finished = fired && (cyc >= fire_cyc + 3);
            else finished = (n_done[0] > 0) && (n_done[1] > 0);
            if (cyc > 400) begin check("load_timeout_cycles", cyc, 400); finished = 1; end
        end
        word_valid = 0;
        repeat (2) @(posedge prog_clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (mode == 0 || mode == 3) begin
                check($sformatf("shift_count[%0d]", d), n_shift[d], cl(d));
                check($sformatf("done_count[%0d]", d), n_done[d], 1);
                check($sformatf("abort_count[%0d]", d), n_abort[d], 0);
                check($sformatf("ready_cycles[%0d]", d), n_rdy[d], 3 + gap_total);
`ifdef CCFF_LOADER_READBACK_EN
                check($sformatf("rb_count[%0d]", d), n_rb[d], cl(d));
`endif
            end else if (mode == 2) begin
                check($sformatf("abort_count[%0d]", d), n_abort[d], 1);
                check($sformatf("abort_no_done[%0d]", d), n_done[d], 0);
                check($sformatf("abort_shifts[%0d]", d), n_shift[d], stop_at + 1);
            end else begin
                check($sformatf("reset_no_done[%0d]", d), n_done[d] + n_abort[d], 0);
            end
        end
        if (mode == 0 || mode == 3) begin
            check("chain_image[0]", chain0, exp_img(0));
            check("chain_image[1]", chain1, exp_img(1));
        end
    endtask

    task automatic idle_start_abort();
        start = 1; abort = 1;
        @(posedge prog_clk); #1;
        start = 0; abort = 0;
        @(negedge prog_clk);
        check("start_abort_in_idle", {word_ready, busy, aborted}, 0);
        @(posedge prog_clk); #1;
    endtask

    task automatic set_words(input logic [WW-1:0] a, input logic [WW-1:0] b, input logic [WW-1:0] c,
                             input int g0, input int g1, input int g2);
        words[0] = a; words[1] = b; words[2] = c;
        gaps[0] = g0; gaps[1] = g1; gaps[2] = g2;
    endtask

    initial begin
        prog_reset_n = 0; start = 0; abort = 0; word_valid = 0; word_data = '0;
        for (int d = 0; d < 2; d++) begin prev_se[d] = 0; acc_pend[d] = 0; end
        repeat (2) @(posedge prog_clk);
        @(negedge prog_clk);
        check("reset_state", {word_ready, ccff_head, shift_en, busy, done, aborted}, 0);
        @(posedge prog_clk); #1;
        prog_reset_n = 1;
        @(posedge prog_clk); #1;

        set_words(8'hA5, 8'h3C, 8'h0F, 0, 0, 0);
        run_load(0, 0);
        set_words(8'hFF, 8'hFF, 8'hF3, 0, 0, 0);
        run_load(0, 0);
        set_words(8'hA5, 8'h3C, 8'h0F, 0, 5, 0);
        run_load(0, 0);
        set_words(8'h5A, 8'hC3, 8'h81, 0, 0, 0);
        run_load(1, 10);
        set_words(8'hA5, 8'h3C, 8'h0F, 0, 0, 0);
        run_load(0, 0);
        set_words(8'h12, 8'h34, 8'h56, 0, 0, 0);
        run_load(2, 5);
        set_words(8'h96, 8'h69, 8'hE7, 0, 0, 0);
        run_load(3, 12);
        idle_start_abort();
        for (int i = 0; i < 6; i++) begin
            set_words(WW'($urandom_range(0, 255)), WW'($urandom_range(0, 255)), WW'($urandom_range(0, 255)),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            run_load(0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0t expected below 200000", $time);
        $fatal(1);
    end

endmodule
